// File: rtl/offset_tracker_pkg.sv
// Shared types and helpers for the multi-channel ADC bias tracker.
// Per-channel state, the default geometry and the saturating offset subtract.
package offset_tracker_pkg;

  typedef enum logic [1:0] {
    ST_CAL   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_TRACK = 2'd2
  } cal_state_t;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_CHANNELS   = 2;
  localparam int DEF_LOG2_N     = 12;
  localparam int DEF_TRIM_W     = 5;
  localparam int DEF_TRIM_SHIFT = 0;

  // Operands are carried at 32 bits so any WIDTH/trim geometry compares without wrap;
  // the caller keeps the low WIDTH bits, which always hold the result since it never exceeds avg.
  function automatic logic [31:0] sat_sub(input logic [31:0] avg,
                                          input logic [31:0] trim_shifted);
    return (avg > trim_shifted) ? (avg - trim_shifted) : 32'd0;
  endfunction

endpackage

// File: rtl/offset_tracker_if.sv
// Sample-side and result-side signals of the offset tracker.
// The ADC/control side drives through master; the tracker consumes through slave.
interface offset_tracker_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int TRIM_W   = 5
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      sampleValid;
  logic [CH_W-1:0]           sampleChan;
  logic [WIDTH-1:0]          sampleVoltage;
  logic [TRIM_W-1:0]         trim;
  logic                      trackMode;
  logic [CHANNELS-1:0]       recal;
  logic [CHANNELS*WIDTH-1:0] offset;
  logic [CHANNELS-1:0]       offsetValid;
  logic                      busy;

  modport master (
    output sampleValid, sampleChan, sampleVoltage, trim, trackMode, recal,
    input  offset, offsetValid, busy
  );

  modport slave (
    input  sampleValid, sampleChan, sampleVoltage, trim, trackMode, recal,
    output offset, offsetValid, busy
  );
endinterface

// File: rtl/offset_channel.sv
// One channel of the bias tracker: calibration average, hold, and leaky-integrator tracking.
// offset_o follows the accumulator one cycle after each accepted update.
module offset_channel
  import offset_tracker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit_i,
  input  logic [WIDTH-1:0]  sample_i,
  input  logic              recal_i,
  input  logic              track_mode_i,
  input  logic [31:0]       trim_shifted_i,
  output logic [WIDTH-1:0]  offset_o,
  output logic              valid_o,
  output logic              cal_o
);
  localparam int ACC_W = WIDTH + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  cal_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] offset_q, offset_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;

  logic [WIDTH-1:0] avg;
  logic [ACC_W-1:0] acc_leak;

  assign avg = acc_q[ACC_W-1:LOG2_N];
  // Never overflows: at full scale acc - (acc >> N) leaves exactly 2^WIDTH of headroom.
  assign acc_leak = acc_q - (acc_q >> LOG2_N) + ACC_W'(sample_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CAL;
      acc_q    <= '0;
      cnt_q    <= '0;
      offset_q <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;

    // The output register trails the accumulator by one edge and is frozen in CAL.
    if (upd_q && (state_q != ST_CAL)) begin
      offset_d = WIDTH'(sat_sub(32'(avg), trim_shifted_i));
    end

    if (recal_i) begin
      state_d = ST_CAL;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_CAL: begin
          if (hit_i) begin
            acc_d = acc_q + ACC_W'(sample_i);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = track_mode_i ? ST_TRACK : ST_HOLD;
              valid_d = 1'b1;
              upd_d   = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (track_mode_i) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!track_mode_i) begin
            state_d = ST_HOLD;
          end else if (hit_i) begin
            acc_d = acc_leak;
            upd_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_CAL;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign offset_o = offset_q;
  assign valid_o  = valid_q;
  assign cal_o    = (state_q == ST_CAL);

endmodule

// File: rtl/offset_tracker.sv
// Multi-channel ADC bias tracker: routes tagged samples to per-channel calibrators.
// The trim value is captured only while reset is held.
module offset_tracker
  import offset_tracker_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int LOG2_N     = DEF_LOG2_N,
  parameter int TRIM_W     = DEF_TRIM_W,
  parameter int TRIM_SHIFT = DEF_TRIM_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  offset_tracker_if.slave  bus
);
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic [31:0]         trim_shifted;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] valid_w;
  logic [CHANNELS-1:0] cal_w;
  logic [WIDTH-1:0]    offset_w [CHANNELS];

  assign trim_d = reset ? bus.trim : trim_q;

  always_ff @(posedge clk) begin
    trim_q <= trim_d;
  end

  assign trim_shifted = 32'(trim_q) << TRIM_SHIFT;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Tags >= CHANNELS match no instance and are therefore dropped.
      assign hit[gi] = bus.sampleValid && (32'(bus.sampleChan) == gi);

      offset_channel #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
      ) u_ch (
        .clk            (clk),
        .reset          (reset),
        .hit_i          (hit[gi]),
        .sample_i       (bus.sampleVoltage),
        .recal_i        (bus.recal[gi]),
        .track_mode_i   (bus.trackMode),
        .trim_shifted_i (trim_shifted),
        .offset_o       (offset_w[gi]),
        .valid_o        (valid_w[gi]),
        .cal_o          (cal_w[gi])
      );

      assign bus.offset[gi*WIDTH +: WIDTH] = offset_w[gi];
    end
  endgenerate

  assign bus.offsetValid = valid_w;
  assign bus.busy        = |cal_w;

endmodule

// File: tb/tb_offset_tracker.sv
// Bench for offset_tracker: directed vectors, a behavioural model checked every cycle,
// and hand-computed literal checkpoints.
module tb_offset_tracker;
  import offset_tracker_pkg::*;

  localparam int WIDTH      = 10;
  localparam int CH         = 2;
  localparam int LOG2_N     = 4;
  localparam int TRIM_W     = 5;
  localparam int TRIM_SHIFT = 0;
  localparam int NSAMP      = 1 << LOG2_N;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;

  offset_tracker_if #(.WIDTH(WIDTH), .CHANNELS(CH), .TRIM_W(TRIM_W)) bus ();

  offset_tracker #(
    .WIDTH(WIDTH), .CHANNELS(CH), .LOG2_N(LOG2_N),
    .TRIM_W(TRIM_W), .TRIM_SHIFT(TRIM_SHIFT)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: counts samples, averages by division, applies the offset one edge later.
  cal_state_t m_state [CH];
  int         m_acc   [CH];
  int         m_cnt   [CH];
  bit         m_valid [CH];
  int         m_off   [CH];
  bit         m_pend  [CH];
  int         m_pval  [CH];
  int         m_trim;

  function automatic int model_offset(input int acc, input int trim);
    int a;
    int t;
    a = acc / NSAMP;
    t = trim << TRIM_SHIFT;
    return (a > t) ? a - t : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_trim <= int'(bus.trim);
      for (int k = 0; k < CH; k++) begin
        m_state[k] <= ST_CAL;
        m_acc[k]   <= 0;
        m_cnt[k]   <= 0;
        m_valid[k] <= 1'b0;
        m_off[k]   <= 0;
        m_pend[k]  <= 1'b0;
        m_pval[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        automatic bit         hit  = bus.sampleValid && (int'(bus.sampleChan) == k);
        automatic int         smp  = int'(bus.sampleVoltage);
        automatic cal_state_t st   = m_state[k];
        automatic int         acc  = m_acc[k];
        automatic int         cnt  = m_cnt[k];
        automatic bit         vld  = m_valid[k];
        automatic bit         pend = 1'b0;
        if (m_pend[k]) m_off[k] <= m_pval[k];
        if (bus.recal[k]) begin
          st = ST_CAL; acc = 0; cnt = 0; vld = 1'b0;
        end else if (st == ST_CAL) begin
          if (hit) begin
            acc = acc + smp;
            cnt = cnt + 1;
            if (cnt == NSAMP) begin
              st   = bus.trackMode ? ST_TRACK : ST_HOLD;
              vld  = 1'b1;
              pend = 1'b1;
            end
          end
        end else if (st == ST_HOLD) begin
          if (bus.trackMode) st = ST_TRACK;
        end else begin
          if (!bus.trackMode) st = ST_HOLD;
          else if (hit) begin
            acc  = acc - acc / NSAMP + smp;
            pend = 1'b1;
          end
        end
        m_state[k] <= st;
        m_acc[k]   <= acc;
        m_cnt[k]   <= cnt;
        m_valid[k] <= vld;
        m_pend[k]  <= pend;
        m_pval[k]  <= pend ? model_offset(acc, m_trim) : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit any_cal = 1'b0;
      for (int k = 0; k < CH; k++) begin
        check($sformatf("model_offset%0d", k), 32'(bus.offset[k*WIDTH +: WIDTH]), 32'(m_off[k]));
        check($sformatf("model_valid%0d", k), 32'(bus.offsetValid[k]), 32'(m_valid[k]));
        if (m_state[k] == ST_CAL) any_cal = 1'b1;
      end
      check("model_busy", 32'(bus.busy), 32'(any_cal));
    end
  end

  // One clock edge with the given inputs; returns at the following negedge.
  task automatic cycle(input bit v, input int ch, input int volt, input logic [CH-1:0] rc);
    bus.sampleValid   = v;
    bus.sampleChan    = 1'(ch);
    bus.sampleVoltage = 10'(volt);
    bus.recal         = rc;
    @(negedge clk);
    $display("[TB] t=%0t v=%0b ch=%0d volt=%0d recal=%b -> offset=%0d/%0d valid=%b busy=%0b",
             $time, v, ch, volt, rc, bus.offset[WIDTH +: WIDTH], bus.offset[0 +: WIDTH],
             bus.offsetValid, bus.busy);
    bus.sampleValid = 1'b0;
    bus.recal       = '0;
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 2'b00);
  endtask

  task automatic do_reset(input int t);
    bus.trim = 5'(t);
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.trim = '0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.sampleValid   = 1'b0;
    bus.sampleChan    = '0;
    bus.sampleVoltage = '0;
    bus.trim          = '0;
    bus.trackMode     = 1'b0;
    bus.recal         = '0;
    @(negedge clk);

    // Reset with trim=3, calibrate ch0 on 200s.
    do_reset(3);
    chk_en = 1'b1;
    check("rst_valid", 32'(bus.offsetValid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_offset", 32'(bus.offset), 32'd0);
    repeat (NSAMP - 1) cycle(1'b1, 0, 200, 2'b00);
    check("cal15_valid", 32'(bus.offsetValid), 32'd0);
    cycle(1'b1, 0, 200, 2'b00);
    check("cal16_valid", 32'(bus.offsetValid), 32'b01);
    check("cal16_off_lag", 32'(bus.offset[0 +: WIDTH]), 32'd0);
    idle();
    check("cal_off0", 32'(bus.offset[0 +: WIDTH]), 32'd197);
    check("cal_off1", 32'(bus.offset[WIDTH +: WIDTH]), 32'd0);
    check("cal_busy", 32'(bus.busy), 32'd1);

    // HOLD ignores samples.
    repeat (20) cycle(1'b1, 0, 1023, 2'b00);
    idle();
    check("hold_off0", 32'(bus.offset[0 +: WIDTH]), 32'd197);

    // HOLD -> TRACK without recalculation, then one tracked sample.
    bus.trackMode = 1'b1;
    idle();
    idle();
    check("trk_enter_off0", 32'(bus.offset[0 +: WIDTH]), 32'd197);
    cycle(1'b1, 0, 216, 2'b00);
    check("trk_lag_off0", 32'(bus.offset[0 +: WIDTH]), 32'd197);
    idle();
    check("trk_off0", 32'(bus.offset[0 +: WIDTH]), 32'd198);
    bus.trackMode = 1'b0;
    idle();
    cycle(1'b1, 0, 0, 2'b00);
    idle();
    check("trk_hold_off0", 32'(bus.offset[0 +: WIDTH]), 32'd198);

    // Calibrate ch1 on 40s.
    repeat (NSAMP) cycle(1'b1, 1, 40, 2'b00);
    idle();
    check("ch1_off", 32'(bus.offset[WIDTH +: WIDTH]), 32'd37);
    check("ch1_valid", 32'(bus.offsetValid), 32'b11);
    check("ch1_busy", 32'(bus.busy), 32'd0);

    // Recal ch0 colliding with a ch0 sample: the sample must be dropped.
    cycle(1'b1, 0, 80, 2'b01);
    check("recal_valid", 32'(bus.offsetValid), 32'b10);
    check("recal_off0_kept", 32'(bus.offset[0 +: WIDTH]), 32'd198);
    check("recal_off1", 32'(bus.offset[WIDTH +: WIDTH]), 32'd37);
    check("recal_busy", 32'(bus.busy), 32'd1);
    repeat (NSAMP - 1) cycle(1'b1, 0, 80, 2'b00);
    check("recal15_valid", 32'(bus.offsetValid), 32'b10);
    cycle(1'b1, 0, 80, 2'b00);
    check("recal16_valid", 32'(bus.offsetValid), 32'b11);
    idle();
    check("recal_off0", 32'(bus.offset[0 +: WIDTH]), 32'd77);

    // Holding recal[1] with ch1 samples keeps it in CAL, offset frozen.
    repeat (3) cycle(1'b1, 1, 40, 2'b10);
    check("recal_hold_valid", 32'(bus.offsetValid), 32'b01);
    check("recal_hold_off1", 32'(bus.offset[WIDTH +: WIDTH]), 32'd37);

    // Saturation: trim=31 against an average of 10.
    do_reset(31);
    repeat (NSAMP) cycle(1'b1, 1, 10, 2'b00);
    idle();
    check("sat_off1", 32'(bus.offset[WIDTH +: WIDTH]), 32'd0);
    check("sat_valid", 32'(bus.offsetValid), 32'b10);

    // Calibrate straight into TRACK, then one leaky update.
    do_reset(3);
    bus.trackMode = 1'b1;
    repeat (NSAMP) cycle(1'b1, 0, 100, 2'b00);
    idle();
    check("trk2_off0", 32'(bus.offset[0 +: WIDTH]), 32'd97);
    cycle(1'b1, 0, 116, 2'b00);
    idle();
    check("trk2_upd_off0", 32'(bus.offset[0 +: WIDTH]), 32'd98);
    bus.trackMode = 1'b0;

    // Reset mid-calibration discards the partial sum.
    do_reset(3);
    repeat (NSAMP / 2) cycle(1'b1, 0, 50, 2'b00);
    do_reset(3);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    check("midrst_valid", 32'(bus.offsetValid), 32'd0);
    check("midrst_offset", 32'(bus.offset), 32'd0);
    repeat (NSAMP - 1) cycle(1'b1, 0, 50, 2'b00);
    check("midrst15_valid", 32'(bus.offsetValid), 32'd0);
    cycle(1'b1, 0, 50, 2'b00);
    idle();
    check("midrst_off0", 32'(bus.offset[0 +: WIDTH]), 32'd47);
    check("midrst_valid_end", 32'(bus.offsetValid), 32'b01);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
